// File: rtl/bus_request_dma_if.sv
// bus_request_dma_if: command, bus-arbitration and memory-bus signals of the copy engine.
// Command: Start, SrcAddr, DstAddr, Count in; Busy, Done out.
// Arbitration: BusRequest out, BusGrant in. Memory: ADDR, DataOut, MemRead, MemWrite out; MEMDATA in.
interface bus_request_dma_if;
  logic        Start;
  logic [15:0] SrcAddr;
  logic [15:0] DstAddr;
  logic [7:0]  Count;
  logic        Busy;
  logic        Done;
  logic        BusRequest;
  logic        BusGrant;
  logic [15:0] ADDR;
  logic [7:0]  MEMDATA;
  logic [7:0]  DataOut;
  logic        MemRead;
  logic        MemWrite;
  modport master (
    output Start, SrcAddr, DstAddr, Count, BusGrant, MEMDATA,
    input  Busy, Done, BusRequest, ADDR, DataOut, MemRead, MemWrite
  );
  modport slave (
    input  Start, SrcAddr, DstAddr, Count, BusGrant, MEMDATA,
    output Busy, Done, BusRequest, ADDR, DataOut, MemRead, MemWrite
  );
endinterface

// File: rtl/bus_request_dma.sv
// bus_request_dma: burst-limited memory-to-memory byte copier that borrows the bus from the CPU pipeline.
// Ports: ClockIn (rising-edge clock), Reset_n (async active-low), bus (slave side of bus_request_dma_if).
module bus_request_dma #(
  parameter int MAX_BURST = 16
) (
  input logic             ClockIn,
  input logic             Reset_n,
  bus_request_dma_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  logic [2:0]  state;
  logic [15:0] src;
  logic [15:0] dst;
  logic [8:0]  remaining;
  logic [8:0]  burst;
  logic [7:0]  data;
  logic        pend;
  logic        done_q;
  // pend marks a byte already read whose write was cut off by a lost grant;
  // it is written straight after re-grant without a fresh read.
  always_ff @(posedge ClockIn or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      burst     <= '0;
      data      <= '0;
      pend      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.Start && !done_q) begin
          src       <= bus.SrcAddr;
          dst       <= bus.DstAddr;
          remaining <= (bus.Count == 8'd0) ? 9'd256 : {1'b0, bus.Count};
          pend      <= 1'b0;
          state     <= REQ;
        end
        REQ: if (bus.BusGrant) begin
          burst <= 9'(MAX_BURST);
          state <= pend ? WRITE : READ;
        end
        READ: if (bus.BusGrant) begin
          data  <= bus.MEMDATA;
          state <= WRITE;
        end else begin
          state <= REQ;
        end
        WRITE: if (!bus.BusGrant) begin
          pend  <= 1'b1;
          state <= REQ;
        end else begin
          src       <= src + 16'd1;
          dst       <= dst + 16'd1;
          remaining <= remaining - 9'd1;
          burst     <= burst - 9'd1;
          pend      <= 1'b0;
          done_q    <= (remaining == 9'd1);
          state     <= (remaining == 9'd1) ? IDLE : (burst == 9'd1) ? GAP : READ;
        end
        GAP: state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end
  // Outputs decode the state register; the write strobe is additionally
  // gated by the live grant so a write never lands on a reclaimed bus.
  always_comb begin
    bus.Busy       = (state != IDLE);
    bus.Done       = done_q;
    bus.BusRequest = (state == REQ) || (state == READ) || (state == WRITE);
    bus.MemRead    = (state == READ);
    bus.MemWrite   = (state == WRITE) && bus.BusGrant;
    bus.ADDR       = (state == READ) ? src : (state == WRITE) ? dst : 16'h0000;
    bus.DataOut    = (state == WRITE) ? data : 8'h00;
  end
endmodule

// File: tb/tb_bus_request_dma.sv
// tb_bus_request_dma: randomized copy runs checked against a sequential byte-copy reference and timing formulas.
module tb_bus_request_dma;
  localparam int MB = 4;
  typedef struct {
    logic [15:0] s;
    logic [15:0] d;
    logic [7:0]  v;
  } xfer_t;
  logic clk;
  logic rst_n;
  logic [7:0] mem [65536];
  xfer_t expq[$];
  int checks = 0;
  int errors = 0;
  int gmode = 0;
  int popped = 0;
  logic [15:0] last_dst = '0;
  bus_request_dma_if bus ();
  bus_request_dma #(.MAX_BURST(MB)) dut (
    .ClockIn (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );
  assign bus.MEMDATA = mem[bus.ADDR];
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Grant modes: 0 tied high, 1 follows BusRequest one cycle late, 2 random drops.
  initial begin
    logic req_d;
    bus.BusGrant = 1'b0;
    forever begin
      @(negedge clk);
      req_d = bus.BusRequest;
      @(posedge clk);
      #1;
      bus.BusGrant = (gmode == 0) ? 1'b1 : (gmode == 1) ? req_d : ($urandom_range(3) != 0);
    end
  end
  // Bus monitor: every read must target the next pending source byte, every
  // write must match the next expected (address, data) pair in order.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !bus.Busy) begin
        check("idle_addr", bus.ADDR, 0);
        check("idle_data", bus.DataOut, 0);
      end
      if (bus.MemRead) begin
        if (expq.size() == 0) check("read_unexpected", 1, 0);
        else check("read_addr", bus.ADDR, expq[0].s);
      end
      if (bus.MemWrite) begin
        if (expq.size() == 0) check("write_unexpected", 1, 0);
        else begin
          check("write_addr", bus.ADDR, expq[0].d);
          check("write_data", bus.DataOut, expq[0].v);
          void'(expq.pop_front());
        end
        mem[bus.ADDR] = bus.DataOut;
        last_dst = bus.ADDR;
        popped++;
      end
    end
  end
  // Reference: plain sequential byte copy, overlap-aware via a shadow of bytes written so far.
  task automatic plan(input logic [15:0] s, input logic [15:0] d, input int len);
    logic [7:0] sh [int];
    for (int i = 0; i < len; i++) begin
      logic [15:0] sa;
      logic [15:0] da;
      logic [7:0]  v;
      sa = s + 16'(i);
      da = d + 16'(i);
      v = sh.exists(int'(sa)) ? sh[int'(sa)] : mem[sa];
      sh[int'(da)] = v;
      expq.push_back('{sa, da, v});
    end
  endtask
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.SrcAddr = s;
    bus.DstAddr = d;
    bus.Count = c;
  endtask
  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c, input int mode, input bit poke);
    int len;
    int b;
    int j;
    int ten;
    int gl;
    bit prev;
    bit gbad;
    len = (c == 8'd0) ? 256 : int'(c);
    b = (len + MB - 1) / MB;
    expq.delete();
    plan(s, d, len);
    gmode = mode;
    popped = 0;
    issue(s, d, c);
    j = 0;
    ten = 0;
    gl = 0;
    prev = 1'b0;
    gbad = 1'b0;
    while (j < 6000) begin
      @(negedge clk);
      j++;
      bus.Start = poke && (j == 5 || j == 9);
      if (bus.Start) begin
        bus.SrcAddr = 16'($urandom);
        bus.DstAddr = 16'($urandom);
        bus.Count = 8'($urandom);
      end
      if (bus.Done) break;
      if (bus.BusRequest && !prev) ten++;
      if (!bus.BusRequest) gl++;
      else if (gl > 0) begin
        if (gl != 1) gbad = 1'b1;
        gl = 0;
      end
      prev = bus.BusRequest;
    end
    bus.Start = poke;
    check("done_seen", bus.Done, 1);
    check("req_at_done", bus.BusRequest, 0);
    check("busy_at_done", bus.Busy, 0);
    check("all_written", expq.size(), 0);
    check("byte_count", popped, len);
    if (mode < 2) begin
      check("done_cycle", j, 2 * len + ((mode == 0) ? 2 : 3) * b);
      check("tenures", ten, b);
      check("gap_len", gbad, 0);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    check("done_single", bus.Done, 0);
    check("start_at_done_ignored", bus.Busy, 0);
    expq.delete();
  endtask
  initial begin
    int k;
    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.SrcAddr = '0;
    bus.DstAddr = '0;
    bus.Count = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1000] = 8'hA5;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.Busy, 0);
    check("rst_req", bus.BusRequest, 0);
    check("rst_done", bus.Done, 0);
    check("rst_rd", bus.MemRead, 0);
    check("rst_wr", bus.MemWrite, 0);
    check("rst_addr", bus.ADDR, 0);
    check("rst_dout", bus.DataOut, 0);
    rst_n = 1'b1;
    run(16'h1000, 16'h2000, 8'd1, 0, 1'b0);
    check("single_val", mem[16'h2000], 8'hA5);
    run(16'h0100, 16'h0800, 8'd10, 1, 1'b0);
    run(16'hFF80, 16'hFFF0, 8'd0, 0, 1'b0);
    check("wrap_last_dst", last_dst, 16'h00EF);
    run(16'h0200, 16'h0900, 8'd12, 2, 1'b1);
    for (int t = 0; t < 16; t++)
      run(16'($urandom), 16'($urandom), (t % 5 == 4) ? 8'd0 : 8'($urandom_range(1, 40)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    expq.delete();
    plan(16'h3000, 16'h4000, 8);
    gmode = 0;
    popped = 0;
    issue(16'h3000, 16'h4000, 8'd8);
    @(negedge clk);
    bus.Start = 1'b0;
    k = 0;
    while (popped < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reset_wait", popped, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_req", bus.BusRequest, 0);
    check("mid_rst_rd", bus.MemRead, 0);
    check("mid_rst_wr", bus.MemWrite, 0);
    check("mid_rst_addr", bus.ADDR, 0);
    check("mid_rst_dout", bus.DataOut, 0);
    expq.delete();
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_done", bus.Done, 0);
    end
    rst_n = 1'b1;
    run(16'h3000, 16'h5000, 8'd8, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
